seg7_scan_drv: RTL and testbench

- Downstream display stage for `top`: drives the 4-digit multiplexed 7-segment display through the `num[6:0]` and `n_mask[3:0]` pins.
- Consumes a 16-bit value, four hex nibbles, with a load strobe.
- Time-multiplexes the digits with a programmable slot length and anti-ghosting dead time.
- New values are applied only at frame boundaries, so a display frame never tears.

---
 rtl/seg7_scan_drv_pkg.sv | 28 ++
 rtl/seg7_scan_drv_hex_dec.sv | 35 +++
 rtl/seg7_scan_drv.sv | 133 +++++++++++++
 tb/tb_seg7_scan_drv.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_drv_pkg.sv
// Shared display constants: blank codes, digit count and active-low segment codes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seg7_scan_drv_pkg;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [3:0] MASK_OFF = 4'hF;
    localparam int         NDIG     = 4;

    // Active-low segment codes, bit0=a ... bit6=g.
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/seg7_scan_drv_hex_dec.sv
// Hex nibble to active-low 7-segment code decoder.
// Latency: combinational.
// Backpressure: none.
module seg7_hex_dec
    import seg7_scan_drv_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    // Plain lookup of the sixteen hex glyphs.
    always_comb begin
        seg_o = SEG_OFF;
        case (nib_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_drv.sv
// 4-digit multiplexed 7-segment scan driver with dead time and frame-aligned value update.
// Latency: outputs registered, one cycle after the (cnt, idx, disp) state they reflect.
// Backpressure: none; load always accepted, last load before a frame boundary wins.
// Optional: define SEG7_LZB_EN for leading-zero blanking.
module seg7_scan_drv
    import seg7_scan_drv_pkg::*;
#(
    parameter int unsigned DIV  = 2500,
    parameter int unsigned DEAD = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic        load,
    output logic [6:0]  num,
    output logic [3:0]  n_mask,
    output logic        frame_done
);

    localparam int unsigned CW = $clog2(DIV);
    localparam int unsigned IW = $clog2(NDIG);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] DEAD_C  = CW'(DEAD);
    localparam logic [IW-1:0] IDX_MAX = IW'(NDIG - 1);

    logic [CW-1:0] cnt_q,    cnt_d;
    logic [IW-1:0] idx_q,    idx_d;
    logic [15:0]   pend_q,   pend_d;
    logic          pend_v_q, pend_v_d;
    logic [15:0]   disp_q,   disp_d;
    logic [6:0]    num_q,    num_d;
    logic [3:0]    mask_q,   mask_d;
    logic          fd_q,     fd_d;

    logic          tick;
    logic          boundary;
    logic [3:0]    nib_sel;
    logic [6:0]    seg_dec;
    logic          blank;

    assign tick     = (cnt_q == CNT_MAX);
    assign boundary = tick && (idx_q == IDX_MAX);

    // Nibble for the digit currently being scanned.
    always_comb begin
        nib_sel = disp_q[3:0];
        case (idx_q)
            2'd0: nib_sel = disp_q[3:0];
            2'd1: nib_sel = disp_q[7:4];
            2'd2: nib_sel = disp_q[11:8];
            2'd3: nib_sel = disp_q[15:12];
            default: nib_sel = disp_q[3:0];
        endcase
    end

    seg7_hex_dec u_dec (
        .nib_i (nib_sel),
        .seg_o (seg_dec)
    );

`ifdef SEG7_LZB_EN
    // A digit above 0 is dark when it and every more-significant nibble is zero.
    always_comb begin
        blank = 1'b0;
        case (idx_q)
            2'd1: blank = (disp_q[15:4]  == 12'h000);
            2'd2: blank = (disp_q[15:8]  == 8'h00);
            2'd3: blank = (disp_q[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    // Prescaler, digit index and shadow/display value updates.
    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        idx_d    = tick ? idx_q + 1'b1 : idx_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        disp_d   = disp_q;
        // Commit first so a load in the boundary cycle lands in pend for the next frame.
        if (boundary && pend_v_q) begin
            disp_d   = pend_q;
            pend_v_d = 1'b0;
        end
        if (load) begin
            pend_d   = digits;
            pend_v_d = 1'b1;
        end
    end

    // Output stage: decode and digit select from the current scan state.
    always_comb begin
        fd_d = boundary;
        if (blank) begin
            num_d  = SEG_OFF;
            mask_d = MASK_OFF;
        end else begin
            num_d  = seg_dec;
            mask_d = (cnt_q < DEAD_C) ? MASK_OFF : ~(4'b0001 << idx_q);
        end
    end

    // State and output registers; reset drops any pending load and blanks the display.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            disp_q   <= '0;
            num_q    <= SEG_OFF;
            mask_q   <= MASK_OFF;
            fd_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            disp_q   <= disp_d;
            num_q    <= num_d;
            mask_q   <= mask_d;
            fd_q     <= fd_d;
        end
    end

    assign num        = num_q;
    assign n_mask     = mask_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Bench for seg7_scan_drv at DIV=8, DEAD=2: timeline reference model plus vector table.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg7_scan_drv;

    localparam int DIV   = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = 4 * DIV;

    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] digits = '0;
    logic        load = 1'b0;
    logic [6:0]  num;
    logic [3:0]  n_mask;
    logic        frame_done;

    int n_err = 0;
    int n_chk = 0;

    // Reference state: edges since reset release, shown value, pending value.
    int          m_t = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_pend = '0;
    bit          m_pv = 1'b0;

    typedef struct {
        logic [15:0]     d;
        logic [3:0][6:0] en;
        logic [3:0][3:0] em;
    } vec_t;
    vec_t vt [5];

    seg7_scan_drv #(.DIV(DIV), .DEAD(DEAD)) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .load       (load),
        .num        (num),
        .n_mask     (n_mask),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0d)", nm, act, exp, m_t);
        end
    endtask

    task automatic model_reset();
        m_t    = 0;
        m_disp = '0;
        m_pend = '0;
        m_pv   = 1'b0;
    endtask

    // One clock with the model predicting every output from time position and value.
    task automatic cyc();
        logic        ld;
        logic [15:0] dg;
        int          slot, off;
        logic [3:0]  nib;
        bit          blank;
        logic [6:0]  e_num;
        logic [3:0]  e_mask;
        bit          e_fd;
        ld = load;
        dg = digits;
        @(posedge clk);
        slot  = (m_t / DIV) % 4;
        off   = m_t % DIV;
        nib   = m_disp[slot*4 +: 4];
        blank = 1'b0;
`ifdef SEG7_LZB_EN
        blank = (slot > 0) && ((m_disp >> (slot * 4)) == 16'h0);
`endif
        e_num  = blank ? 7'h7F : SEG[nib];
        e_mask = (blank || off < DEAD) ? 4'hF : 4'(~(1 << slot));
        e_fd   = (m_t % FRAME == FRAME - 1);
        if (e_fd && m_pv) begin
            m_disp = m_pend;
            m_pv   = 1'b0;
        end
        if (ld) begin
            m_pend = dg;
            m_pv   = 1'b1;
        end
        m_t++;
        #1;
        chk("cyc_num",  {9'h0, num},        {9'h0, e_num});
        chk("cyc_mask", {12'h0, n_mask},    {12'h0, e_mask});
        chk("cyc_fd",   {15'h0, frame_done}, {15'h0, e_fd});
    endtask

    // Advance until the next edge will be at frame phase ph.
    task automatic run_to(input int ph);
        int n;
        n = 0;
        while ((m_t % FRAME) != ph && n < 2 * FRAME) begin
            cyc();
            n++;
        end
    endtask

    // One full frame from phase 0, checking each digit mid-slot.
    task automatic frame_chk(input string nm, input logic [3:0][6:0] en, input logic [3:0][3:0] em);
        int ph;
        for (int i = 0; i < FRAME; i++) begin
            ph = m_t % FRAME;
            cyc();
            if (ph % DIV == 4) begin
                chk({nm, "_num"},  {9'h0, num},     {9'h0, en[ph/DIV]});
                chk({nm, "_mask"}, {12'h0, n_mask}, {12'h0, em[ph/DIV]});
            end
        end
    endtask

    localparam logic [3:0][3:0] EM_ALL = {4'h7, 4'hB, 4'hD, 4'hE};

    initial begin
        bit got;
        int n;
        vt[0] = '{16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}, EM_ALL};
        vt[1] = '{16'hABCD, {7'h08, 7'h03, 7'h46, 7'h21}, EM_ALL};
        vt[2] = '{16'h8888, {7'h00, 7'h00, 7'h00, 7'h00}, EM_ALL};
        vt[3] = '{16'h5555, {7'h12, 7'h12, 7'h12, 7'h12}, EM_ALL};
`ifdef SEG7_LZB_EN
        vt[4] = '{16'h0070, {7'h7F, 7'h7F, 7'h78, 7'h40}, {4'hF, 4'hF, 4'hD, 4'hE}};
`else
        vt[4] = '{16'h0070, {7'h40, 7'h40, 7'h78, 7'h40}, EM_ALL};
`endif

        // Held in reset with load toggling: outputs stay at reset values.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            load   = ~load;
            digits = 16'h9999;
            #1;
            chk("rst_num",  {9'h0, num},         16'h007F);
            chk("rst_mask", {12'h0, n_mask},     16'h000F);
            chk("rst_fd",   {15'h0, frame_done}, 16'h0000);
        end
        load = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        cyc(); chk("rel_dead0", {12'h0, n_mask}, 16'h000F);
        cyc(); chk("rel_dead1", {12'h0, n_mask}, 16'h000F);
        cyc(); chk("rel_dig0",  {12'h0, n_mask}, 16'h000E);

        // Vector table: load, wait for the committing boundary, check the next frame.
        for (int v = 0; v < 5; v++) begin
            digits = vt[v].d;
            load   = 1'b1;
            cyc();
            load = 1'b0;
            got  = 1'b0;
            n    = 0;
            while (!got && n < 3 * FRAME) begin
                cyc();
                got = frame_done;
                n++;
            end
            chk("tbl_fd_seen", {15'h0, got}, 16'h0001);
            frame_chk("tbl", vt[v].en, vt[v].em);
        end

        // Tear-free: 1234 shown, load ABCD during digit 1.
        digits = 16'h1234; load = 1'b1; cyc(); load = 1'b0;
        run_to(0);
        frame_chk("tf_pre", vt[0].en, vt[0].em);
        run_to(DIV + 3);
        digits = 16'hABCD; load = 1'b1; cyc(); load = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            n = m_t % FRAME;
            cyc();
            if (n == 2 * DIV + 4) chk("tf_dig2", {9'h0, num}, 16'h0024);
            if (n == 3 * DIV + 4) chk("tf_dig3", {9'h0, num}, 16'h0079);
            if (n == FRAME - 1) break;
        end
        frame_chk("tf_post", vt[1].en, vt[1].em);

        // Collision: 8888 pending, 5555 loaded in the boundary cycle itself.
        digits = 16'h8888; load = 1'b1; cyc(); load = 1'b0;
        cyc();
        run_to(FRAME - 1);
        digits = 16'h5555; load = 1'b1; cyc(); load = 1'b0;
        chk("col_fd", {15'h0, frame_done}, 16'h0001);
        frame_chk("col_8888", vt[2].en, vt[2].em);
        frame_chk("col_5555", vt[3].en, vt[3].em);

        // Async reset during digit 2 with a load pending.
        digits = 16'h4321; load = 1'b1; cyc(); load = 1'b0;
        run_to(2 * DIV + 4);
        cyc();
        #2 rst = 1'b0;
        #1;
        chk("ar_num",  {9'h0, num},         16'h007F);
        chk("ar_mask", {12'h0, n_mask},     16'h000F);
        chk("ar_fd",   {15'h0, frame_done}, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
`ifdef SEG7_LZB_EN
        frame_chk("ar_zero", {7'h7F, 7'h7F, 7'h7F, 7'h40}, {4'hF, 4'hF, 4'hF, 4'hE});
`else
        frame_chk("ar_zero", {7'h40, 7'h40, 7'h40, 7'h40}, EM_ALL);
`endif

        // Random loads against the timeline model.
        for (int i = 0; i < 600; i++) begin
            load   = ($urandom_range(0, 7) == 0);
            digits = 16'($urandom);
            if ($urandom_range(0, 3) == 0) digits = digits & 16'h00FF;
            cyc();
        end
        load = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Never more than one digit enabled.
    always @(negedge clk) begin
        if (rst && $countones(~n_mask) > 1) begin
            n_chk++;
            n_err++;
            $display("FAIL onehot_mask: got %h want at most one low bit", n_mask);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1);
    end

endmodule
